// File: rtl/fetch_stage_pkg.sv
// Shared fetch types: ROM address / word typedefs and the queue entry.
// FETCH_MISALIGN_CHECK_EN adds a per-entry misaligned flag.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef logic [ADDR_W-1:0] RomAddress;
  typedef logic [31:0] UWord;

  typedef struct packed {
    RomAddress pc;
    UWord insn;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
`endif
  } FetchEntry;

  // PC value actually loaded from a reset or redirect target.
  function automatic RomAddress pc_load(RomAddress a);
`ifdef FETCH_MISALIGN_CHECK_EN
    return a;
`else
    return {a[ADDR_W-1:2], 2'b00};
`endif
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of FetchEntry with synchronous flush.
// Ports: clk, reset_n, push, pop, flush, wdata, rdata (head), count.
import fetch_stage_pkg::*;

module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  FetchEntry     wdata,
  output FetchEntry     rdata,
  output logic [CW-1:0] count
);

  FetchEntry mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, ROM address, fetch queue, decode handshake.
// Ports: clk, reset_n, rom_address/rom_data, redirect/redirect_pc,
// halt, out_valid/out_ready, out_pc, out_insn
// (+ out_misaligned with FETCH_MISALIGN_CHECK_EN).
import fetch_stage_pkg::*;

module fetch_stage #(
  parameter RomAddress   RESET_PC    = '0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  output RomAddress rom_address,
  input  UWord      rom_data,
  input  logic      redirect,
  input  RomAddress redirect_pc,
  input  logic      halt,
  output logic      out_valid,
  input  logic      out_ready,
  output RomAddress out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic      out_misaligned,
`endif
  output UWord      out_insn
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  RomAddress pc;
  logic [CW-1:0] count;
  logic push;
  logic pop;
  FetchEntry wdata;
  FetchEntry head;

  assign rom_address = pc;
  assign out_valid = (count != '0);

  assign pop  = out_valid & out_ready & ~redirect;
  // A pop frees the head slot, so a full queue can still accept.
  assign push = ~redirect & ~halt & ((count < FULL) | pop);

  always_comb begin
    wdata = '0;
    wdata.pc = pc;
    wdata.insn = rom_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    wdata.misaligned = (pc[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= pc_load(RESET_PC);
    end else if (redirect) begin
      pc <= pc_load(redirect_pc);
    end else if (push) begin
      pc <= pc + RomAddress'(INSN_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata   (wdata),
    .rdata   (head),
    .count   (count)
  );

  // Stale slots are hidden so an empty queue reads as zero.
  assign out_pc   = out_valid ? head.pc : '0;
  assign out_insn = out_valid ? head.insn : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign out_misaligned = out_valid & head.misaligned;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the pipelined RV32 core.
- Owns the program counter and drives the combinational instruction ROM's address each cycle.
- Captures the returned word, together with its PC, into a small in-order fetch queue.
- Presents the queue head to decode with a valid/ready handshake.
- Takes redirects (taken branch/jump, from execute) that flush the queue and reload the PC.

Parameters:
- RESET_PC, 0, byte address loaded into PC on reset.
- QUEUE_DEPTH, 2, fetch-queue entries (power of two, ≥2).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rom_address  out  $bits(RomAddress)  byte address to ROM; always equals PC.
- rom_data  in  32 (UWord)  instruction word returned combinationally by ROM.
- redirect  in  1  flush and load PC from redirect_pc this cycle.
- redirect_pc  in  $bits(RomAddress)  new fetch target.
- halt  in  1  freeze fetching (PC and pushes); draining continues.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  $bits(RomAddress)  PC of head instruction.
- out_insn  out  32 (UWord)  head instruction word.

Behaviour:
- Reset, asynchronous on reset_n low:
  - PC=RESET_PC, queue empty (count=0, rd_ptr=wr_ptr=0).
  - out_valid=0; out_pc and out_insn read 0.
  - Deassertion is synchronised externally. Reset mid-operation discards all entries.
- rom_address = PC (combinational).
- pop = out_valid & out_ready & ~redirect.
- push = ~redirect & ~halt & (count<QUEUE_DEPTH | pop).
- On push: entry {PC, rom_data} is written at wr_ptr, and PC <= PC+4.
  - Addition is modulo 2^$bits(RomAddress); wrap to 0 is legal and silent.
- On pop: rd_ptr advances and the head is removed.
- Simultaneous push+pop at full is legal; count is unchanged.
- Pointers wrap modulo QUEUE_DEPTH. count ranges 0..QUEUE_DEPTH.
- redirect (highest priority):
  - Next edge: count=0, both pointers 0, PC=redirect_pc.
  - No push and no pop that cycle; out_ready is ignored.
- Fetch latency: an instruction at PC X is visible on out_* one cycle after X is driven (registered queue, no bypass). After reset or redirect, the first out_valid is 1 cycle later.
- Steady-state throughput: 1 insn/cycle while out_ready is held high.
- halt: PC frozen and no pushes; pops proceed. Redirect overrides halt for the PC load.
- Full and not popping: PC holds, so the ROM re-reads the same address. No fetch is lost.
- out_valid = (count!=0).
- out_pc/out_insn are stable while out_valid & ~out_ready (no change without pop or redirect).

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Extra output port out_misaligned (1 bit), stored per entry and set when the entry's PC[1:0]!=0.
  - A misaligned redirect_pc is still loaded. Subsequent entries keep the low bits (PC+4 preserves them).
  - Reset value 0.
- Undefined:
  - Port absent.
  - PC[1:0] is forced to 0 on load from RESET_PC and redirect_pc.

Decomposition:
- Shared package types.svh: struct FetchEntry {RomAddress pc; UWord insn;}, constant INSN_BYTES=4.
  - With the feature: FetchEntry gains a misaligned bit under the same macro.
- Reuse the existing RomAddress/UWord typedefs.
- Sub-module fetch_queue: parametric FIFO of FetchEntry.
  - Ports: clk, reset_n, push, pop, flush, wdata, rdata, count.
  - fetch_stage keeps PC logic and handshake.
- A trace macro reports push/pop/redirect events.

Test Plan:
- Reset with ROM words 0x00000013,0x00100093,0x00200113 at 0/4/8, out_ready=1:
  - out_valid rises 1 cycle after reset release.
  - out_pc sequence 0,4,8 with matching insns, one per cycle.
- out_ready=0 for 5 cycles after reset:
  - count saturates at 2, rom_address holds 8, head stays {0,0x00000013}.
  - Raising out_ready yields pc 0,4,8 with no gaps or duplicates.
- redirect=1, redirect_pc=0x40 while queue is full and out_ready=1:
  - Next cycle out_valid=0, no pop is counted, rom_address=0x40.
  - The following cycle out_pc=0x40.
- halt=1 with 2 queued entries, out_ready=1:
  - Both drain (pc 0,4), then out_valid=0 and PC stays 8 until halt drops.
- PC wrap: redirect_pc = max aligned address (all ones minus 3):
  - out_pc sequence is max-3, then 0x0.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc=0x42 gives out_pc=0x42 with out_misaligned=1, then 0x46 with out_misaligned=1.
- Without the macro: the same stimulus yields out_pc=0x40.
